// File: rtl/puf_ctrl_pkg.sv
// Shared types and LFSR helper for the PUF challenge sequencer.
// Pure definitions: no latency, no backpressure.
package puf_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      FIRE,
      SAMPLE,
      RELAX,
      DONE
   } state_e;

   localparam int                    LFSR_WIDTH    = 8;
   localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS     = 8'hB8;
   localparam logic [LFSR_WIDTH-1:0] SEED_ZERO_SUB = 8'h01;

   // Fibonacci step: feedback is the parity of the tapped bits 7,5,4,3.
   function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] c);
      return {c[LFSR_WIDTH-2:0], ^(c & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer for the asynchronous PUF response bit.
// Latency 2 cycles, no backpressure.
module puf_resp_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives LFSR challenges into the arbiter PUF and packs RESP_BITS responses into one word.
// RESP_BITS*(SETUP+EVAL+1+RELAX)+1 cycles start to result; result held until resp_ready.
module puf_challenge_sequencer
   import puf_ctrl_pkg::*;
#(
   parameter int RESP_BITS = 32,
   parameter int SETUP_CYC = 4,
   parameter int EVAL_CYC  = 8,
   parameter int RELAX_CYC = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [7:0]            seed,
   output logic                  puf_trigger,
   output logic [7:0]            puf_challenge,
   input  logic                  puf_response,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [RESP_BITS-1:0]  resp_data,
   output logic                  busy
);

   localparam int MAX_CYC = (SETUP_CYC > EVAL_CYC) ?
                            ((SETUP_CYC > RELAX_CYC) ? SETUP_CYC : RELAX_CYC) :
                            ((EVAL_CYC  > RELAX_CYC) ? EVAL_CYC  : RELAX_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int BIT_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [BIT_W-1:0]        bit_q, bit_d;
   logic [LFSR_WIDTH-1:0]   chal_q, chal_d;
   logic                    trig_q, trig_d;
   logic [RESP_BITS-1:0]    data_q, data_d;
   logic                    resp_sync;

   puf_resp_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (puf_response),
      .q_o (resp_sync)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         chal_q  <= '0;
         trig_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         chal_q  <= chal_d;
         trig_q  <= trig_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      chal_d  = chal_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start_valid) begin
               state_d = SETUP;
               chal_d  = (seed == '0) ? SEED_ZERO_SUB : seed;
               bit_d   = '0;
               data_d  = '0;
            end
         end
         SETUP: begin
            if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
               state_d = FIRE;
               cnt_d   = '0;
            end
         end
         FIRE: begin
            if (cnt_q == CNT_W'(EVAL_CYC - 1)) begin
               state_d = SAMPLE;
               cnt_d   = '0;
            end
         end
         SAMPLE: begin
            data_d[bit_q] = resp_sync;
            state_d       = RELAX;
            cnt_d         = '0;
         end
         RELAX: begin
            if (cnt_q == CNT_W'(RELAX_CYC - 1)) begin
               cnt_d = '0;
               if (bit_q == BIT_W'(RESP_BITS - 1)) begin
                  state_d = DONE;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  chal_d  = lfsr_next(chal_q);
                  state_d = SETUP;
               end
            end
         end
         DONE: begin
            cnt_d = '0;
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      // Trigger is registered from the next state so it leaves a flop with no decode glitches.
      trig_d = (state_d == FIRE);
   end

   assign start_ready   = (state_q == IDLE);
   assign busy          = (state_q != IDLE) && (state_q != DONE);
   assign resp_valid    = (state_q == DONE);
   assign resp_data     = data_q;
   assign puf_trigger   = trig_q;
   assign puf_challenge = chal_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Randomized bench: a 6-bit instance against an XOR-parity core model, and a
// default 32-bit instance with a protocol checker and a late-glitching constant-1 core.
module tb_puf_challenge_sequencer;

   localparam int NA     = 6;
   localparam int NB     = 32;
   localparam int PERIOD = 4 + 8 + 1 + 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          a_start_valid = 1'b0, a_start_ready;
   logic [7:0]    a_seed = '0;
   logic          a_trig;
   logic [7:0]    a_chal;
   logic          a_resp_in = 1'b0;
   logic          a_resp_valid;
   logic          a_resp_ready = 1'b0;
   logic [NA-1:0] a_resp_data;
   logic          a_busy;

   logic          b_start_valid = 1'b0, b_start_ready;
   logic [7:0]    b_seed = '0;
   logic          b_trig;
   logic [7:0]    b_chal;
   logic          b_resp_in = 1'b1;
   logic          b_resp_valid;
   logic          b_resp_ready = 1'b0;
   logic [NB-1:0] b_resp_data;
   logic          b_busy;

   int            checks = 0;
   int            failures = 0;

   logic [7:0]    a_chal_q[$];
   logic [NA-1:0] a_last_data;

   int            b_rises = 0, b_bad_hi = 0, b_bad_gap = 0, b_chal_chg = 0;
   int            b_hi_len = 0, b_lo_len = 0;
   logic          b_prev = 1'b0;
   logic [7:0]    b_last_chal = '0;

   always #5 clk = ~clk;

   puf_challenge_sequencer #(.RESP_BITS(NA)) dut_a (
      .clk(clk), .rst(rst),
      .start_valid(a_start_valid), .start_ready(a_start_ready), .seed(a_seed),
      .puf_trigger(a_trig), .puf_challenge(a_chal), .puf_response(a_resp_in),
      .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data),
      .busy(a_busy)
   );

   puf_challenge_sequencer dut_b (
      .clk(clk), .rst(rst),
      .start_valid(b_start_valid), .start_ready(b_start_ready), .seed(b_seed),
      .puf_trigger(b_trig), .puf_challenge(b_chal), .puf_response(b_resp_in),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
      .busy(b_busy)
   );

   // Core A: response is the parity of the challenge, latched on trigger rise.
   always @(posedge a_trig) begin
      a_chal_q.push_back(a_chal);
      a_resp_in = ^a_chal;
   end

   // Protocol checker for B; core B answers 1 but drops to 0 in the last FIRE cycle.
   always @(negedge clk) begin
      if (rst) begin
         b_rises = 0; b_bad_hi = 0; b_bad_gap = 0; b_chal_chg = 0;
         b_hi_len = 0; b_lo_len = 0; b_prev = 1'b0;
      end else begin
         if (b_trig) begin
            if (!b_prev) begin
               b_rises++;
               if (b_rises > 1 && b_lo_len != 9) b_bad_gap++;
               b_hi_len    = 0;
               b_last_chal = b_chal;
            end
            b_hi_len++;
            if (b_chal != b_last_chal) b_chal_chg++;
         end else begin
            if (b_prev) begin
               if (b_hi_len != 8) b_bad_hi++;
               b_lo_len = 0;
            end
            b_lo_len++;
         end
         b_prev = b_trig;
      end
      b_resp_in = !(b_trig && b_hi_len == 8);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_chal(input logic [7:0] sd, input int idx);
      logic [7:0] c;
      c = (sd == 8'h00) ? 8'h01 : sd;
      for (int i = 0; i < idx; i++) c = {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
      return c;
   endfunction

   function automatic logic [63:0] exp_word(input logic [7:0] sd, input int n);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < n; i++) w[i] = ^exp_chal(sd, i);
      return w;
   endfunction

   task automatic run_a(input logic [7:0] sd, input int hold);
      int n;
      logic [NA-1:0] exp_d;
      exp_d = exp_word(sd, NA)[NA-1:0];
      @(negedge clk);
      a_chal_q.delete();
      check("a_start_ready_idle", a_start_ready, 1);
      a_seed = sd;
      a_start_valid = 1'b1;
      @(posedge clk); #1;
      a_start_valid = 1'b0;
      n = 0;
      while (!a_resp_valid && n < 2000) begin
         @(posedge clk); n++; #1;
         if (!a_resp_valid) a_resp_ready = 1'($urandom_range(0, 1));
      end
      check("a_latency", n + 1, NA * PERIOD + 1);
      check("a_resp_data", a_resp_data, exp_d);
      a_last_data = a_resp_data;
      check("a_num_chal", a_chal_q.size(), NA);
      for (int i = 0; i < NA && i < a_chal_q.size(); i++)
         check("a_chal", a_chal_q[i], exp_chal(sd, i));
      if (hold == 0) begin
         a_resp_ready = 1'b1;
         @(posedge clk); #1;
         check("a_done_one_cycle", a_resp_valid, 0);
         check("a_ready_after_hs", a_start_ready, 1);
      end else begin
         a_resp_ready = 1'b0;
         for (int i = 0; i < hold; i++) begin
            a_start_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("a_hold_valid", a_resp_valid, 1);
            check("a_hold_data", a_resp_data, exp_d);
            check("a_hold_start_ready", a_start_ready, 0);
         end
         a_start_valid = 1'b0;
         a_resp_ready  = 1'b1;
         @(posedge clk); #1;
         check("a_release_valid", a_resp_valid, 0);
         check("a_release_ready", a_start_ready, 1);
      end
      a_resp_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] rs;
      int n;
      #1;
      check("rst_trigger", a_trig, 0);
      check("rst_challenge", a_chal, 0);
      check("rst_resp_valid", a_resp_valid, 0);
      check("rst_resp_data", a_resp_data, 0);
      check("rst_busy", a_busy, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_start_ready", a_start_ready, 1);

      // 32-bit run: protocol shape and synchronizer latency
      b_seed = 8'($urandom);
      b_start_valid = 1'b1;
      b_resp_ready = 1'b1;
      @(posedge clk); #1;
      b_start_valid = 1'b0;
      n = 0;
      while (!b_resp_valid && n < 2000) begin
         @(posedge clk); n++; #1;
      end
      check("b_latency", n + 1, NB * PERIOD + 1);
      check("b_resp_data_ones", b_resp_data, {NB{1'b1}});
      check("b_rises", b_rises, NB);
      check("b_bad_high_len", b_bad_hi, 0);
      check("b_bad_low_gap", b_bad_gap, 0);
      check("b_chal_change_hi", b_chal_chg, 0);
      @(posedge clk); #1;
      check("b_valid_dropped", b_resp_valid, 0);
      check("b_busy_idle", b_busy, 0);
      b_resp_ready = 1'b0;

      // Directed 6-bit cases, then random seeds and hold lengths
      run_a(8'h01, 0);
      check("a_seed01_word", a_last_data, 6'h2F);
      run_a(8'h00, 0);
      check("a_seed00_word", a_last_data, 6'h2F);
      run_a(8'h01, 20);
      for (int k = 0; k < 5; k++) begin
         rs = 8'($urandom);
         run_a(rs, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6)));
      end

      // Reset in the 3rd FIRE window
      @(negedge clk);
      a_chal_q.delete();
      a_seed = 8'h01;
      a_start_valid = 1'b1;
      @(posedge clk); #1;
      a_start_valid = 1'b0;
      n = 0;
      while (a_chal_q.size() < 3 && n < 500) begin
         @(posedge clk); n++; #1;
      end
      check("rst_mid_reached_fire3", a_trig, 1);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_trigger", a_trig, 0);
      check("rst_mid_challenge", a_chal, 0);
      check("rst_mid_valid", a_resp_valid, 0);
      check("rst_mid_data", a_resp_data, 0);
      check("rst_mid_busy", a_busy, 0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (120) begin
         @(posedge clk); #1;
         if (a_resp_valid) n++;
      end
      check("rst_mid_no_valid", n, 0);
      run_a(8'h01, 0);
      check("rst_mid_rerun_word", a_last_data, 6'h2F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
